// File: rtl/freq_sweep_ctrl.sv
// Frequency-select code sequencer for the step generator.
// Sweeps sel_code between latched bounds, holding each code for the dwell time.
module freq_sweep_ctrl #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic               loop_en,
    input  logic [2:0]         code_lo,
    input  logic [2:0]         code_hi,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel_code,
    output logic               busy,
    output logic               step_pulse,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_DOWN = 2'b01;
    localparam logic [1:0] M_PP   = 2'b10;

    localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state_q;
    logic [2:0]         sel_q;
    logic [2:0]         first_q;
    logic [2:0]         lo_q;
    logic [2:0]         hi_q;
    logic [1:0]         mode_q;
    logic               loop_q;
    logic               dir_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt_q;
    logic               busy_q;
    logic               step_q;
    logic               done_q;
    logic               err_q;

    logic [2:0] sel_d;
    logic       dir_d;
    logic       step_d;
    logic       term_d;
    logic [2:0] first_d;
    logic       bad_cfg;

    assign first_d = (mode == M_DOWN) ? code_hi : code_lo;
    assign bad_cfg = (code_lo > code_hi) || (dwell == '0);

    // Next code at dwell expiry; hold mode neither steps nor terminates.
    always_comb begin
        sel_d  = sel_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        term_d = 1'b0;
        case (mode_q)
            M_UP: begin
                if (sel_q < hi_q) begin
                    sel_d  = sel_q + 3'd1;
                    step_d = 1'b1;
                end else begin
                    term_d = 1'b1;
                end
            end
            M_DOWN: begin
                if (sel_q > lo_q) begin
                    sel_d  = sel_q - 3'd1;
                    step_d = 1'b1;
                end else begin
                    term_d = 1'b1;
                end
            end
            M_PP: begin
                if (lo_q == hi_q) begin
                    term_d = 1'b1;
                end else if (!dir_q) begin
                    step_d = 1'b1;
                    if (sel_q < hi_q) begin
                        sel_d = sel_q + 3'd1;
                    end else begin
                        dir_d = 1'b1;
                        sel_d = sel_q - 3'd1;
                    end
                end else if (sel_q > lo_q) begin
                    sel_d  = sel_q - 3'd1;
                    step_d = 1'b1;
                end else begin
                    term_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            first_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            mode_q  <= '0;
            loop_q  <= 1'b0;
            dir_q   <= 1'b0;
            dwell_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            step_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        if (bad_cfg) begin
                            err_q <= 1'b1;
                        end else begin
                            mode_q  <= mode;
                            loop_q  <= loop_en;
                            lo_q    <= code_lo;
                            hi_q    <= code_hi;
                            dwell_q <= dwell;
                            first_q <= first_d;
                            sel_q   <= first_d;
                            dir_q   <= 1'b0;
                            cnt_q   <= dwell - ONE;
                            busy_q  <= 1'b1;
                            step_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - ONE;
                    end else if (step_d) begin
                        sel_q  <= sel_d;
                        dir_q  <= dir_d;
                        cnt_q  <= dwell_q - ONE;
                        step_q <= 1'b1;
                    end else if (term_d && loop_q) begin
                        sel_q  <= first_q;
                        dir_q  <= 1'b0;
                        cnt_q  <= dwell_q - ONE;
                        step_q <= 1'b1;
                    end else if (term_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sel_code   = sel_q;
    assign busy       = busy_q;
    assign step_pulse = step_q;
    assign done       = done_q;
    assign cfg_err    = err_q;

endmodule
